au_acc_sequencer: RTL and testbench

//  Command sequencer and accumulator wrapped around the combinational 4-bit arithmetic unit (AU).
//  - Accepts op/operand commands over a valid/ready handshake.
//  - Drives the AU: A = accumulator; B, Cin and S latched from the command.
//  - Writes AU Y back into the accumulator once per cycle, for a programmable repeat count.
//  - Returns the accumulator and flags over a valid/ready result handshake.
//  - The AU is instantiated beside this block in the parent, not inside it.

---
 rtl/au_pkg.sv | 18 +
 rtl/au_acc_sequencer.sv | 106 ++++++++++
 tb/tb_au_acc_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/au_pkg.sv
// Shared definitions for the 4-bit arithmetic unit and its command sequencer.
// Holds the AU select encodings, the sequencer state encoding and the default data width.
package au_pkg;

  localparam int AU_WIDTH = 4;

  localparam logic [1:0] AU_ADD = 2'b00;
  localparam logic [1:0] AU_INC = 2'b01;
  localparam logic [1:0] AU_DEC = 2'b10;
  localparam logic [1:0] AU_SHL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/au_acc_sequencer.sv
// Command sequencer and accumulator driving an external combinational AU.
// Runs cmd_rep+1 chained AU iterations per command and returns acc plus carry flags.
module au_acc_sequencer
  import au_pkg::*;
#(
  parameter int WIDTH = AU_WIDTH,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_cin,
  input  logic [REP_W-1:0] cmd_rep,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic             au_cin,
  output logic [1:0]       au_s,
  input  logic [WIDTH-1:0] au_y,
  input  logic [3:0]       au_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_c,
  output logic             res_ovf,
  output logic             res_z
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [1:0]       op_q;
  logic [REP_W-1:0] cnt;
  logic             c_q;
  logic             ovf_q;
  logic             carry_sel;

  // The AU reports every op's carry at once; only the selected op's bit matters.
  assign carry_sel = au_cout[op_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      op_q  <= 2'b00;
      cnt   <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            c_q   <= 1'b0;
            ovf_q <= 1'b0;
            if (cmd_load) begin
              acc   <= cmd_b;
              state <= ST_DONE;
            end else begin
              op_q  <= cmd_op;
              b_q   <= cmd_b;
              cin_q <= cmd_cin;
              cnt   <= cmd_rep;
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          acc   <= au_y;
          c_q   <= carry_sel;
          ovf_q <= ovf_q | carry_sel;
          // Counter holds the remaining iterations after this one, so all-ones runs 2**REP_W times.
          if (cnt == '0) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - REP_W'(1);
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign res_valid = (state == ST_DONE);
  assign res_data  = acc;
  assign res_c     = c_q;
  assign res_ovf   = ovf_q;
  assign res_z     = (acc == '0);

  assign au_a   = acc;
  assign au_b   = b_q;
  assign au_cin = cin_q;
  assign au_s   = op_q;

endmodule

// File: tb/tb_au_acc_sequencer.sv
// Self-checking bench for au_acc_sequencer with a behavioural AU beside it.
// Directed spec scenarios followed by randomized commands checked against an arithmetic model.
module tb_au_acc_sequencer;
  import au_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_load, cmd_cin;
  logic [1:0] cmd_op;
  logic [3:0] cmd_b, cmd_rep;
  logic [3:0] au_a, au_b, au_y;
  logic       au_cin;
  logic [1:0] au_s;
  logic [3:0] au_cout;
  logic       res_valid, res_ready, res_c, res_ovf, res_z;
  logic [3:0] res_data;

  int checks = 0;
  int errors = 0;
  logic [3:0] acc_m;

  au_acc_sequencer #(.WIDTH(4), .REP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_rep(cmd_rep),
    .au_a(au_a), .au_b(au_b), .au_cin(au_cin), .au_s(au_s),
    .au_y(au_y), .au_cout(au_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_c(res_c), .res_ovf(res_ovf), .res_z(res_z)
  );

  always #5 clk = ~clk;

  // Behavioural AU: all four carries computed in parallel, Y picked by S.
  always_comb begin
    int sum, a;
    a = int'(au_a);
    sum = a + int'(au_b) + int'(au_cin);
    au_cout[0] = (sum > 15);
    au_cout[1] = (a == 15);
    au_cout[2] = (a == 0);
    au_cout[3] = au_a[3];
    case (au_s)
      AU_ADD:  au_y = 4'(sum % 16);
      AU_INC:  au_y = 4'((a + 1) % 16);
      AU_DEC:  au_y = 4'((a + 15) % 16);
      default: au_y = 4'((a * 2) % 16);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: iterate the op rep+1 times on plain integers.
  function automatic void model(input bit ld, input logic [1:0] op, input logic [3:0] b,
                                input bit cin, input logic [3:0] rep, input logic [3:0] a0,
                                output logic [3:0] acc, output bit c, output bit ovf);
    int a, r;
    bit cy;
    a = int'(a0); c = 0; ovf = 0;
    if (ld) begin
      acc = b;
      return;
    end
    for (int i = 0; i <= int'(rep); i++) begin
      case (op)
        AU_ADD:  begin r = a + int'(b) + int'(cin); cy = (r > 15); end
        AU_INC:  begin r = a + 1; cy = (r > 15); end
        AU_DEC:  begin r = a - 1; cy = (a == 0); if (r < 0) r += 16; end
        default: begin r = a * 2; cy = (r > 15); end
      endcase
      a = r % 16;
      c = cy;
      ovf = ovf | cy;
    end
    acc = 4'(a);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_load = 1'b0; cmd_op = 2'b00; cmd_b = 4'h0; cmd_cin = 1'b0; cmd_rep = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_z", res_z, 1);
    check("rst_au_bus", {au_a, au_b, au_cin, au_s}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = 4'h0;
  endtask

  task automatic run_cmd(input bit ld, input logic [1:0] op, input logic [3:0] b,
                         input bit cin, input logic [3:0] rep, input int hold);
    logic [3:0] e_acc;
    bit e_c, e_ovf;
    int n, exp_n;
    model(ld, op, b, cin, rep, acc_m, e_acc, e_c, e_ovf);
    exp_n = ld ? 1 : int'(rep) + 2;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_b = b; cmd_cin = cin; cmd_rep = rep;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_b = 4'($urandom); cmd_op = 2'($urandom); cmd_cin = 1'($urandom);
    n = 1;
    while (!res_valid && n < 40) begin
      if (!ld) begin
        check("exec_au_s", au_s, op);
        check("exec_au_b", {au_cin, au_b}, {cin, b});
      end
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, exp_n);
    check("res_valid", res_valid, 1);
    check("res_data", res_data, e_acc);
    check("res_flags", {res_c, res_ovf, res_z}, {e_c, e_ovf, e_acc == 4'h0});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      res_ready = 1'b0; cmd_valid = 1'b1; cmd_load = 1'($urandom); cmd_b = 4'($urandom);
      @(posedge clk);
      #1;
      check("hold_stable", {res_valid, cmd_ready, res_data, res_c, res_ovf},
            {1'b1, 1'b0, e_acc, e_c, e_ovf});
    end
    @(negedge clk);
    res_ready = 1'b1; cmd_valid = 1'b1; cmd_load = 1'b1; cmd_b = ~e_acc;
    check("take_cmd_ready", cmd_ready, 0);
    @(posedge clk);
    #1;
    res_ready = 1'b0; cmd_valid = 1'b0;
    check("after_take", {cmd_ready, res_valid}, 2'b10);
    check("acc_retained", au_a, e_acc);
    acc_m = e_acc;
  endtask

  initial begin
    do_reset();

    run_cmd(1, AU_ADD, 4'h9, 0, 4'h0, 0);
    check("t1_load", acc_m, 4'h9);
    run_cmd(0, AU_ADD, 4'h8, 0, 4'h0, 0);
    check("t1_add", {acc_m, res_c, res_ovf}, {4'h1, 1'b1, 1'b1});

    run_cmd(1, AU_ADD, 4'h0, 0, 4'h0, 0);
    run_cmd(0, AU_INC, 4'h0, 0, 4'hF, 0);
    check("t2_inc", {acc_m, res_c, res_ovf, res_z}, {4'h0, 1'b1, 1'b1, 1'b1});

    run_cmd(1, AU_ADD, 4'b0011, 0, 4'h0, 0);
    run_cmd(0, AU_SHL, 4'h0, 0, 4'h1, 0);
    check("t3_shl2", {acc_m, res_c, res_ovf}, {4'b1100, 1'b0, 1'b0});
    run_cmd(0, AU_SHL, 4'h0, 0, 4'h0, 0);
    check("t3_shl1", {acc_m, res_c, res_ovf}, {4'b1000, 1'b1, 1'b1});

    run_cmd(1, AU_ADD, 4'h5, 0, 4'h0, 0);
    run_cmd(0, AU_DEC, 4'h0, 0, 4'h2, 5);
    check("t4_dec", {acc_m, res_z}, {4'h2, 1'b0});

    // Abort an in-flight command with reset.
    run_cmd(1, AU_ADD, 4'h3, 0, 4'h0, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = AU_INC; cmd_b = 4'h0; cmd_rep = 4'hA;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_abort", {au_a, res_valid, cmd_ready, res_z}, {4'h0, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = 4'h0;
    begin
      bit seen = 0;
      for (int i = 0; i < 15; i++) begin
        @(posedge clk);
        #1;
        seen |= res_valid;
      end
      check("t6_no_result", seen, 0);
    end

    for (int k = 0; k < 25; k++) begin
      run_cmd(($urandom_range(0, 3) == 0), 2'($urandom), 4'($urandom), 1'($urandom),
              4'($urandom), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
